// File: rtl/enemy_hit_detector.sv
// Enemy hit detector: collects shot/wall overlaps per frame and pulses on the next frame boundary.
// Optional frame-based hit cooldown is enabled with the ENEMY_HIT_COOLDOWN_EN macro.
`timescale 1ns/1ps
module enemy_hit_detector #(
  parameter int COOLDOWN_FRAMES = 4,
  parameter int MAX_HITS        = 255
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enemyDR,
  input  logic       shotDR,
  input  logic       boundaryDR,
  output logic       shotCollision,
  output logic       changeDirection,
  output logic [7:0] hitCount,
  output logic       cooldownActive
);

  typedef enum logic {ARMED = 1'b0, COOLDOWN = 1'b1} state_t;

  localparam logic [7:0] MAX_HITS_C = 8'(MAX_HITS);

  state_t     state_q, state_d;
  logic       hitPending_q, hitPending_d;
  logic       wallPending_q, wallPending_d;
  logic       shotCollision_q, shotCollision_d;
  logic       changeDirection_q, changeDirection_d;
  logic [7:0] hitCount_q, hitCount_d;
  logic       shot_ov, wall_ov;

`ifdef ENEMY_HIT_COOLDOWN_EN
  localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN_FRAMES);
  logic [7:0] frameCnt_q, frameCnt_d;
  logic       cooldownActive_q;
`endif

  assign shot_ov = enemyDR & shotDR;
  assign wall_ov = enemyDR & boundaryDR;

  always_comb begin
    state_d           = state_q;
    hitPending_d      = hitPending_q;
    wallPending_d     = wallPending_q;
    shotCollision_d   = 1'b0;
    changeDirection_d = 1'b0;
    hitCount_d        = hitCount_q;
`ifdef ENEMY_HIT_COOLDOWN_EN
    frameCnt_d        = frameCnt_q;
`endif
    if (startOfFrame) begin
      // Decide on last frame's flags, then restart them with this cycle's overlap.
      changeDirection_d = wallPending_q;
      if (state_q == ARMED) begin
        if (hitPending_q) begin
          shotCollision_d = 1'b1;
          if (hitCount_q < MAX_HITS_C)
            hitCount_d = hitCount_q + 8'd1;
`ifdef ENEMY_HIT_COOLDOWN_EN
          frameCnt_d = COOLDOWN_C;
          state_d    = COOLDOWN;
`endif
        end
      end else begin
`ifdef ENEMY_HIT_COOLDOWN_EN
        frameCnt_d = frameCnt_q - 8'd1;
        if (frameCnt_q == 8'd1)
          state_d = ARMED;
`endif
      end
      hitPending_d  = shot_ov && (state_d == ARMED);
      wallPending_d = wall_ov;
    end else begin
      if (shot_ov && (state_q == ARMED))
        hitPending_d = 1'b1;
      if (wall_ov)
        wallPending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q           <= ARMED;
      hitPending_q      <= 1'b0;
      wallPending_q     <= 1'b0;
      shotCollision_q   <= 1'b0;
      changeDirection_q <= 1'b0;
      hitCount_q        <= 8'd0;
`ifdef ENEMY_HIT_COOLDOWN_EN
      frameCnt_q        <= 8'd0;
      cooldownActive_q  <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      hitPending_q      <= hitPending_d;
      wallPending_q     <= wallPending_d;
      shotCollision_q   <= shotCollision_d;
      changeDirection_q <= changeDirection_d;
      hitCount_q        <= hitCount_d;
`ifdef ENEMY_HIT_COOLDOWN_EN
      frameCnt_q        <= frameCnt_d;
      cooldownActive_q  <= (state_d == COOLDOWN);
`endif
    end
  end

  assign shotCollision   = shotCollision_q;
  assign changeDirection = changeDirection_q;
  assign hitCount        = hitCount_q;
`ifdef ENEMY_HIT_COOLDOWN_EN
  assign cooldownActive  = cooldownActive_q;
`else
  assign cooldownActive  = 1'b0;
`endif

endmodule

// File: tb/tb_enemy_hit_detector.sv
// Self-checking bench for enemy_hit_detector: frame-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_enemy_hit_detector;
  localparam int COOLDOWN_FRAMES = 4;
  localparam int MAX_HITS        = 3;
`ifdef ENEMY_HIT_COOLDOWN_EN
  localparam int CD = COOLDOWN_FRAMES;
`else
  localparam int CD = 0;
`endif
  localparam logic CDE = (CD > 0);

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0, enemyDR = 1'b0, shotDR = 1'b0, boundaryDR = 1'b0;
  logic       shotCollision, changeDirection, cooldownActive;
  logic [7:0] hitCount;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  enemy_hit_detector #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES), .MAX_HITS(MAX_HITS)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enemyDR(enemyDR),
    .shotDR(shotDR), .boundaryDR(boundaryDR), .shotCollision(shotCollision),
    .changeDirection(changeDirection), .hitCount(hitCount), .cooldownActive(cooldownActive));

  // Frame-level model: a frame runs from one startOfFrame cycle up to the next.
  // blk = number of upcoming frames (including the current one) in which shots are ignored.
  int   blk = 0;
  int   hits = 0;
  bit   shot_seen = 0, wall_seen = 0;
  logic e_sc = 0, e_cd = 0, e_ca = 0;
  logic [7:0] e_hc = 0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blk = 0; hits = 0; shot_seen = 0; wall_seen = 0;
      e_sc = 0; e_cd = 0; e_ca = 0; e_hc = 0;
    end else begin
      if (startOfFrame) begin
        e_sc = shot_seen;
        e_cd = wall_seen;
        if (shot_seen) begin
          if (hits < MAX_HITS) hits++;
          blk = CD;
        end else if (blk > 0) begin
          blk--;
        end
        shot_seen = enemyDR && shotDR && (blk == 0);
        wall_seen = enemyDR && boundaryDR;
      end else begin
        e_sc = 0;
        e_cd = 0;
        if (enemyDR && shotDR && (blk == 0)) shot_seen = 1;
        if (enemyDR && boundaryDR) wall_seen = 1;
      end
      e_ca = (blk > 0);
      e_hc = 8'(hits);
    end
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("shotCollision", {7'd0, shotCollision}, {7'd0, e_sc});
      cmp("changeDirection", {7'd0, changeDirection}, {7'd0, e_cd});
      cmp("hitCount", hitCount, e_hc);
      cmp("cooldownActive", {7'd0, cooldownActive}, {7'd0, e_ca});
    end
  end

  task automatic cyc(input bit sof, input bit e, input bit s, input bit b);
    @(posedge clk);
    #2;
    startOfFrame = sof; enemyDR = e; shotDR = s; boundaryDR = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic frame(input int len, input bit sof_shot, input int shot_at, input int wall_at);
    cyc(1, sof_shot, sof_shot, 1'b0);
    for (int i = 1; i < len; i++)
      cyc(0, (i == shot_at) || (i == wall_at), i == shot_at, i == wall_at);
  endtask

  // Boundary with no overlap, then park mid-cycle where the boundary's outputs are visible.
  task automatic boundary_peek();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #4;
  endtask

  task automatic drain();
    repeat (4) frame(6, 0, -1, -1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    resetN = 1'b0; startOfFrame = 0; enemyDR = 0; shotDR = 0; boundaryDR = 0;
    #4;
    cmp("rst_shotCollision", {7'd0, shotCollision}, 8'd0);
    cmp("rst_changeDirection", {7'd0, changeDirection}, 8'd0);
    cmp("rst_hitCount", hitCount, 8'd0);
    cmp("rst_cooldownActive", {7'd0, cooldownActive}, 8'd0);
    repeat (n) @(posedge clk);
    #2;
    resetN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #2;
    resetN = 1'b1;
    chk_en = 1'b1;
    do_reset(2);

    // Single overlap pixel -> one pulse after the next boundary
    frame(8, 0, 3, -1);
    boundary_peek();
    cmp("t1_shotCollision", {7'd0, shotCollision}, 8'd1);
    cmp("t1_hitCount", hitCount, 8'd1);
    cmp("t1_cooldownActive", {7'd0, cooldownActive}, {7'd0, CDE});
    cyc(0, 0, 0, 0);
    #4;
    cmp("t1_pulse_width", {7'd0, shotCollision}, 8'd0);
    idle(4);
    drain();

    // Overlap on the startOfFrame cycle counts toward the next boundary
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);
    #4;
    cmp("t2_no_pulse_same_boundary", {7'd0, shotCollision}, 8'd0);
    idle(6);
    boundary_peek();
    cmp("t2_pulse_next_boundary", {7'd0, shotCollision}, 8'd1);
    cmp("t2_hitCount", hitCount, 8'd2);
    idle(6);
    drain();

    // Shot and wall in the same frame pulse together
    frame(10, 0, 2, 5);
    boundary_peek();
    cmp("t3_shotCollision", {7'd0, shotCollision}, 8'd1);
    cmp("t3_changeDirection", {7'd0, changeDirection}, 8'd1);
    cmp("t3_hitCount", hitCount, 8'd3);
    idle(6);
    drain();

    // Saturation at MAX_HITS
    repeat (2) begin
      frame(6, 0, 1, -1);
      boundary_peek();
      cmp("t4_shotCollision", {7'd0, shotCollision}, 8'd1);
      cmp("t4_hitCount_sat", hitCount, 8'd3);
      idle(4);
      drain();
    end

    // Overlap every frame for ten boundaries
    do_reset(1);
    pulses = 0;
    for (int k = 0; k <= 10; k++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 0);
      #4;
      if (k > 0 && shotCollision === 1'b1) pulses++;
      idle(4);
    end
    vectors++;
    if (pulses != (CDE ? 2 : 10)) begin
      errors++;
      $display("FAIL t5_pulse_count: got %0d, expected %0d", pulses, (CDE ? 2 : 10));
    end
    cmp("t5_hitCount", hitCount, CDE ? 8'd2 : 8'd3);
    drain();

    // Reset during cooldown with events pending discards them
    frame(6, 0, 1, -1);
    boundary_peek();
    cmp("t6_hit", {7'd0, shotCollision}, 8'd1);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 0, 0);
    do_reset(1);
    cyc(0, 0, 0, 0);
    boundary_peek();
    cmp("t6_no_shot_after_reset", {7'd0, shotCollision}, 8'd0);
    cmp("t6_no_wall_after_reset", {7'd0, changeDirection}, 8'd0);
    idle(3);
    frame(5, 0, 2, -1);
    boundary_peek();
    cmp("t6_new_hit", {7'd0, shotCollision}, 8'd1);
    cmp("t6_new_hitCount", hitCount, 8'd1);
    idle(3);

    // Random frames against the model
    for (int f = 0; f < 300; f++) begin
      int len;
      len = $urandom_range(3, 20);
      cyc(1, ($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0);
      for (int i = 1; i < len; i++) begin
        if (($urandom % 700) == 0) begin
          do_reset($urandom_range(1, 2));
        end else begin
          cyc(0, ($urandom % 3) == 0, ($urandom % 5) == 0, ($urandom % 7) == 0);
        end
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
